multi_port_register_file: RTL and testbench
===========================================

// Module: multi_port_register_file
// PURPOSE
//  Parametrised general-purpose register file for the core: DEPTH x WIDTH storage,
//  NRD independent read ports, one write port with optional write-to-read bypass,
//  optional registered reads, and a sequenced bulk-clear engine. Sits between
//  decode (read addresses) and writeback (write port); feeds operand latches/ALU.
// PARAMETERS
//  WIDTH     16  data bits per register
//  DEPTH     8   number of registers (power of two, >=2); AW = $clog2(DEPTH)
//  NRD       2   number of read ports (1..4)
//  BYPASS    1   1: same-cycle write data forwarded to matching read port
//  READ_REG  0   0: combinational read; 1: rdata registered (1-cycle latency)
//  ZERO_REG  0   1: entry 0 reads as 0 and ignores writes and clears
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  raddr     in   NRD*AW     read addresses; port i = raddr[i*AW +: AW]
//  rdata     out  NRD*WIDTH  read data; port i = rdata[i*WIDTH +: WIDTH]
//  we        in   1          write enable, accepted only when wr_ready=1
//  waddr     in   AW         write address
//  wdata     in   WIDTH      write data
//  wr_ready  out  1          1 = write port accepts; 0 during clear
//  clr_req   in   1          request bulk clear (level; sampled in IDLE only)
//  clr_busy  out  1          1 while clear sequence runs
//  clr_done  out  1          1-cycle pulse on the last clear write
// BEHAVIOUR
//  Reset (rst_n=0, async): all entries 0, FSM IDLE, clr_idx 0, clr_busy 0,
//   clr_done 0, wr_ready 1, registered rdata (READ_REG=1) 0. Comb rdata follows state.
//  Write: on posedge clk, if we && wr_ready && !(ZERO_REG && waddr==0): mem[waddr]<=wdata.
//   we while wr_ready=0 is dropped (no queueing); caller must hold/retry.
//  Read, READ_REG=0: rdata_i = sel_i in same cycle, where sel_i =
//   0 if ZERO_REG && raddr_i==0; else wdata if BYPASS && we && wr_ready && waddr==raddr_i;
//   else mem[raddr_i].
//  Read, READ_REG=1: rdata_i <= sel_i at posedge; visible cycle N+1 for raddr in N.
//   With BYPASS=0 and same-cycle write to same address, old value is returned.
//  Ports are independent; identical addresses on several ports return identical data.
//  Clear FSM (states IDLE, CLEAR):
//   IDLE: clr_req=1 -> CLEAR, clr_idx<=0. A write in that same cycle still commits.
//   CLEAR: each cycle mem[clr_idx]<=0, clr_idx++; wr_ready=0, clr_busy=1.
//    clr_idx==DEPTH-1: clr_done=1 that cycle, next state IDLE. Clear takes DEPTH cycles.
//   ZERO_REG: entry 0 still walked (DEPTH cycles), write is a no-op.
//   clr_req held high after completion -> one IDLE cycle, then new sequence.
//   Reads during CLEAR return current contents (partially cleared); no bypass then.
//  Reset mid-clear: async abort, IDLE, all entries 0 (reset clears anyway).
//  clr_idx width AW; no wrap past DEPTH-1 (FSM exits first).
// STRUCTURE
//  Package rf_pkg: rf_state_e {RF_IDLE, RF_CLEAR}, rf_clog2 helper function.
//  Sub-module rf_read_port (one per read port via generate): address decode,
//   ZERO_REG/bypass priority mux, optional output register. Storage, write logic
//   and clear FSM stay in top.
// TESTING
//  1 Reset then read all 8 addrs on both ports -> all rdata 16'h0000.
//  2 Write r3=16'hBEEF, next cycle raddr0=3, raddr1=3 -> both 16'hBEEF (READ_REG=0).
//  3 BYPASS=1: we=1 waddr=5 wdata=16'h1234, raddr1=5 same cycle -> rdata1=16'h1234;
//    BYPASS=0 -> old value 16'h0000 that cycle, 16'h1234 next.
//  4 Fill r0..r7 with 16'h0101*i, pulse clr_req -> clr_busy 8 cycles, clr_done on 8th,
//    wr_ready=0 throughout; write r2=16'hFFFF mid-clear dropped; all reads 0 after.
//  5 ZERO_REG=1: write r0=16'hAAAA -> r0 reads 0; bypass to port reading r0 also 0.
//  6 READ_REG=1: raddr0=4 after r4=16'h00C4 -> rdata0 16'h00C4 one cycle later;
//    assert rst_n low mid-clear (idx 3) -> immediate idle, clr_busy 0, rdata 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e : clear-engine states (idle / walking the array with zeros)
//   rf_clog2   : ceiling log2, used to size address fields from DEPTH
package rf_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    function automatic int rf_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port of the register file.
//   clk, rst_n : clock, asynchronous active-low reset (output register only)
//   raddr      : register index for this port
//   mem_flat   : whole storage array, entry i at [i*WIDTH +: WIDTH]
//   wr_fwd     : a write is being accepted this cycle (we && wr_ready)
//   waddr      : write index, wdata : write data (bypass source)
//   rdata      : selected data, combinational or registered per READ_REG
// Select priority: hard-wired zero entry, then same-cycle write bypass,
// then stored contents.
module rf_read_port #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AW-1:0]          raddr,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    input  logic                   wr_fwd,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata
);

    logic [WIDTH-1:0] sel_s;
    logic [WIDTH-1:0] rdata_q;

    // Priority mux: zero entry, then forwarded write data, then storage.
    always_comb begin
        sel_s = '0;
        if ((ZERO_REG != 0) && (raddr == {AW{1'b0}})) begin
            sel_s = '0;
        end else if ((BYPASS != 0) && wr_fwd && (waddr == raddr)) begin
            sel_s = wdata;
        end else begin
            sel_s = mem_flat[int'(raddr)*WIDTH +: WIDTH];
        end
    end

    // Optional output register; unused (and trimmed) when READ_REG = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= sel_s;
        end
    end

    assign rdata = (READ_REG != 0) ? rdata_q : sel_s;

endmodule

// File: rtl/multi_port_register_file.sv
// DEPTH x WIDTH general-purpose register file with NRD read ports, one write
// port and a bulk-clear engine.
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   raddr      : NRD packed read addresses, port i at [i*AW +: AW]
//   rdata      : NRD packed read data, port i at [i*WIDTH +: WIDTH]
//   we/waddr/wdata : write port, accepted only while wr_ready = 1
//   wr_ready   : low while the clear engine owns the array
//   clr_req    : level request for a bulk clear, sampled only when idle
//   clr_busy   : clear sequence in progress (DEPTH cycles)
//   clr_done   : one-cycle pulse on the final clear write
module multi_port_register_file
    import rf_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    parameter  int NRD      = 2,
    parameter  int BYPASS   = 1,
    parameter  int READ_REG = 0,
    parameter  int ZERO_REG = 0,
    localparam int AW       = rf_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    output logic                 wr_ready,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rf_state_e              state_q, state_d;
    logic [AW-1:0]          clr_idx_q, clr_idx_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat_s;
    logic                   wr_fwd_s;
    logic                   wr_commit_s;
    logic                   clr_wr_s;

    assign wr_ready = (state_q == RF_IDLE);
    assign clr_busy = (state_q == RF_CLEAR);
    assign clr_done = (state_q == RF_CLEAR) && (clr_idx_q == LAST_IDX);

    // Entry 0 is never written when it is hard-wired to zero; the clear walk
    // still spends a cycle on it so the sequence is always DEPTH cycles.
    assign wr_fwd_s    = we && wr_ready;
    assign wr_commit_s = wr_fwd_s && !((ZERO_REG != 0) && (waddr == {AW{1'b0}}));
    assign clr_wr_s    = clr_busy && !((ZERO_REG != 0) && (clr_idx_q == {AW{1'b0}}));

    // Clear engine next-state logic.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = {AW{1'b0}};
                end else begin
                    state_d   = RF_IDLE;
                end
            end
            RF_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RF_IDLE;
                    clr_idx_d = {AW{1'b0}};
                end else begin
                    clr_idx_d = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d   = RF_IDLE;
                clr_idx_d = {AW{1'b0}};
            end
        endcase
    end

    // Clear engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_IDLE;
            clr_idx_q <= {AW{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Storage: clear writes and port writes never coincide (wr_ready is low
    // during clear), so the ordering below is only defensive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_wr_s && (clr_idx_q == AW'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_commit_s && (waddr == AW'(i))) begin
                    mem_q[i] <= wdata;
                end
            end
        end
    end

    // Flatten storage for the read-port instances.
    always_comb begin
        mem_flat_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat_s[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rf_read_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .BYPASS  (BYPASS),
            .READ_REG(READ_REG),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .clk     (clk),
            .rst_n   (rst_n),
            .raddr   (raddr[p*AW +: AW]),
            .mem_flat(mem_flat_s),
            .wr_fwd  (wr_fwd_s),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata[p*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench for multi_port_register_file. Three instances share stimulus:
//   A: BYPASS=1 READ_REG=0 ZERO_REG=0 (defaults)
//   B: BYPASS=0 READ_REG=0 ZERO_REG=0
//   C: BYPASS=1 READ_REG=1 ZERO_REG=1 (its rdata reflects the previous cycle)
module tb_multi_port_register_file;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ra0, ra1;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        clr_req;

    logic [31:0] a_rdata, b_rdata, c_rdata;
    logic        a_ready, a_busy, a_done;
    logic        b_ready, b_busy, b_done;
    logic        c_ready, c_busy, c_done;

    int errors;
    int checks;

    multi_port_register_file #(.BYPASS(1), .READ_REG(0), .ZERO_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .raddr({ra1, ra0}), .rdata(a_rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .wr_ready(a_ready),
        .clr_req(clr_req), .clr_busy(a_busy), .clr_done(a_done)
    );

    multi_port_register_file #(.BYPASS(0), .READ_REG(0), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .raddr({ra1, ra0}), .rdata(b_rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .wr_ready(b_ready),
        .clr_req(clr_req), .clr_busy(b_busy), .clr_done(b_done)
    );

    multi_port_register_file #(.BYPASS(1), .READ_REG(1), .ZERO_REG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .raddr({ra1, ra0}), .rdata(c_rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .wr_ready(c_ready),
        .clr_req(clr_req), .clr_busy(c_busy), .clr_done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  r0, r1;
        logic        clr;
        logic [15:0] a0, a1, b0, b1, c0, c1;
        logic        rdy, busy, done;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                                input logic [2:0] r0, input logic [2:0] r1, input logic clr,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] c0, input logic [15:0] c1,
                                input logic rdy, input logic busy, input logic done);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.r0 = r0; v.r1 = r1; v.clr = clr;
        v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.c0 = c0; v.c1 = c1;
        v.rdy = rdy; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 3'd0;
        wdata   = 16'h0000;
        ra0     = 3'd0;
        ra1     = 3'd0;
        clr_req = 1'b0;

        // we  wa   wd        r0 r1 clr  A0       A1       B0       B1       C0       C1      rdy busy done
        vq.push_back(mk(0, 0, 16'h0000, 0, 7, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 1, 6, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 5, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 3, 4, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 3, 16'hBEEF, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 3, 3, 0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 5, 16'h1234, 3, 5, 0, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hBEEF, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 5, 5, 0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hBEEF, 16'h1234, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 5, 0, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 1, 0, 0));
        vq.push_back(mk(1, 0, 16'hAAAA, 0, 3, 0, 16'hAAAA, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h1234, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h0000, 16'hBEEF, 1, 0, 0));
        vq.push_back(mk(1, 4, 16'h00C4, 4, 4, 0, 16'h00C4, 16'h00C4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 4, 0, 0, 16'h00C4, 16'hAAAA, 16'h00C4, 16'hAAAA, 16'h00C4, 16'h00C4, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 3, 4, 0, 16'hBEEF, 16'h00C4, 16'hBEEF, 16'h00C4, 16'h00C4, 16'h0000, 1, 0, 0));
        // Fill r0..r7 with 0x0101*i while reading the target (bypass on A/C).
        vq.push_back(mk(1, 0, 16'h0000, 0, 7, 0, 16'h0000, 16'h0000, 16'hAAAA, 16'h0000, 16'hBEEF, 16'h00C4, 1, 0, 0));
        vq.push_back(mk(1, 1, 16'h0101, 1, 7, 0, 16'h0101, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 2, 16'h0202, 2, 7, 0, 16'h0202, 16'h0000, 16'h0000, 16'h0000, 16'h0101, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 3, 16'h0303, 3, 7, 0, 16'h0303, 16'h0000, 16'hBEEF, 16'h0000, 16'h0202, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 4, 16'h0404, 4, 7, 0, 16'h0404, 16'h0000, 16'h00C4, 16'h0000, 16'h0303, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 5, 16'h0505, 5, 7, 0, 16'h0505, 16'h0000, 16'h1234, 16'h0000, 16'h0404, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 6, 16'h0606, 6, 7, 0, 16'h0606, 16'h0000, 16'h0000, 16'h0000, 16'h0505, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 7, 16'h0707, 7, 7, 0, 16'h0707, 16'h0707, 16'h0000, 16'h0000, 16'h0606, 16'h0000, 1, 0, 0));
        // Clear request, then 8 clear cycles (idx 0..7), write to r2 dropped at idx 2.
        vq.push_back(mk(0, 0, 16'h0000, 2, 6, 1, 16'h0202, 16'h0606, 16'h0202, 16'h0606, 16'h0707, 16'h0707, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0202, 16'h0707, 16'h0202, 16'h0707, 16'h0202, 16'h0606, 0, 1, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0202, 16'h0707, 16'h0202, 16'h0707, 16'h0202, 16'h0707, 0, 1, 0));
        vq.push_back(mk(1, 2, 16'hFFFF, 2, 7, 0, 16'h0202, 16'h0707, 16'h0202, 16'h0707, 16'h0202, 16'h0707, 0, 1, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 16'h0202, 16'h0707, 0, 1, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 0, 1, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 0, 1, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 0, 1, 0));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 16'h0000, 16'h0707, 0, 1, 1));
        vq.push_back(mk(0, 0, 16'h0000, 2, 7, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0707, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 3, 4, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        vq.push_back(mk(0, 0, 16'h0000, 5, 6, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        #1;
        chk("rst A rd", a_rdata[15:0], 16'h0000);
        chk("rst C rd", c_rdata[15:0], 16'h0000);
        chk("rst ready", {15'd0, a_ready}, 16'h0001);
        chk("rst busy", {15'd0, a_busy}, 16'h0000);
        chk("rst done", {15'd0, a_done}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            we = vq[i].we; waddr = vq[i].wa; wdata = vq[i].wd;
            ra0 = vq[i].r0; ra1 = vq[i].r1; clr_req = vq[i].clr;
            #1;
            chk($sformatf("v%0d A rd0", i), a_rdata[15:0],  vq[i].a0);
            chk($sformatf("v%0d A rd1", i), a_rdata[31:16], vq[i].a1);
            chk($sformatf("v%0d B rd0", i), b_rdata[15:0],  vq[i].b0);
            chk($sformatf("v%0d B rd1", i), b_rdata[31:16], vq[i].b1);
            chk($sformatf("v%0d C rd0", i), c_rdata[15:0],  vq[i].c0);
            chk($sformatf("v%0d C rd1", i), c_rdata[31:16], vq[i].c1);
            chk($sformatf("v%0d ready", i), {15'd0, a_ready}, {15'd0, vq[i].rdy});
            chk($sformatf("v%0d busy", i),  {15'd0, a_busy},  {15'd0, vq[i].busy});
            chk($sformatf("v%0d done", i),  {15'd0, a_done},  {15'd0, vq[i].done});
            chk($sformatf("v%0d C busy", i), {15'd0, c_busy}, {15'd0, vq[i].busy});
            chk($sformatf("v%0d B done", i), {15'd0, b_done}, {15'd0, vq[i].done});
        end

        // clr_req held high: 8 busy cycles, one idle cycle, then a new sequence.
        we = 1'b0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            clr_req = 1'b1;
            #1;
            chk($sformatf("hold c%0d busy", c), {15'd0, a_busy}, {15'd0, ((c % 9) != 0)});
            chk($sformatf("hold c%0d done", c), {15'd0, a_done}, {15'd0, ((c % 9) == 8)});
            chk($sformatf("hold c%0d ready", c), {15'd0, a_ready}, {15'd0, ((c % 9) == 0)});
        end
        @(negedge clk);
        clr_req = 1'b0;
        for (int k = 0; k < 20 && a_busy; k++) begin
            @(negedge clk);
        end
        #1;
        chk("hold drain busy", {15'd0, a_busy}, 16'h0000);

        // Async reset in the middle of a clear sequence.
        @(negedge clk);
        we = 1'b1; waddr = 3'd6; wdata = 16'h6666; ra0 = 3'd6; ra1 = 3'd6;
        @(negedge clk);
        we = 1'b0; clr_req = 1'b1;
        #1;
        chk("mid A rd r6", a_rdata[15:0], 16'h6666);
        @(negedge clk);
        clr_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid idx3 busy", {15'd0, a_busy}, 16'h0001);
        chk("mid C rd r6", c_rdata[15:0], 16'h6666);
        rst_n = 1'b0;
        #1;
        chk("abort busy", {15'd0, a_busy}, 16'h0000);
        chk("abort ready", {15'd0, a_ready}, 16'h0001);
        chk("abort done", {15'd0, a_done}, 16'h0000);
        chk("abort A rd", a_rdata[15:0], 16'h0000);
        chk("abort B rd", b_rdata[15:0], 16'h0000);
        chk("abort C rd", c_rdata[15:0], 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post A rd r6", a_rdata[31:16], 16'h0000);
        chk("post busy", {15'd0, a_busy}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
